// File: rtl/btn_step_ctrl.sv
// Single-step / auto-run controller: synchronizes and debounces two raw buttons
// and issues one-cycle step pulses, either per press or at a fixed period.

module btn_step_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          synced;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  assign synced  = sync_q[1];
  assign press_o = press_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = synced;
        press_d  = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

endmodule

module btn_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int RUN_PERIOD      = 25000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        btn_step_i,
  input  logic        btn_run_i,
  output logic        step_o,
  output logic        run_o,
  output logic [15:0] step_cnt_o
);

  localparam int PW = $clog2(RUN_PERIOD);
  localparam logic [PW-1:0] PER_MAX = PW'(RUN_PERIOD - 1);

  typedef enum logic {
    ST_STEP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic          step_q, step_d;
  logic [15:0]   step_cnt_q, step_cnt_d;
  logic          step_press, run_press, period_hit;

  btn_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_step_i),
    .press_o (step_press)
  );

  btn_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_run_i),
    .press_o (run_press)
  );

  assign period_hit = (per_q == PER_MAX);

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    step_d  = 1'b0;
    unique case (state_q)
      ST_STEP: begin
        // A run press wins over a simultaneous step press.
        if (run_press) begin
          state_d = ST_RUN;
          per_d   = '0;
        end else begin
          step_d = step_press;
        end
      end
      ST_RUN: begin
        step_d = period_hit;
        per_d  = period_hit ? '0 : per_q + 1'b1;
        if (run_press) begin
          state_d = ST_STEP;
          per_d   = '0;
        end
      end
      default: state_d = ST_STEP;
    endcase
    step_cnt_d = step_d ? step_cnt_q + 16'd1 : step_cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_STEP;
      per_q      <= '0;
      step_q     <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      step_q     <= step_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step_o     = step_q;
  assign run_o      = (state_q == ST_RUN);
  assign step_cnt_o = step_cnt_q;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Directed bench for btn_step_ctrl with DEBOUNCE_CYCLES=8, RUN_PERIOD=10:
// press latency is 11 edges, run cadence 10 edges.

module tb_btn_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_run = 1'b0;
  logic        step_o;
  logic        run_o;
  logic [15:0] step_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt  = 0;
  int double_cnt = 0;
  logic prev_step = 1'b0;

  always #5 clk = ~clk;

  btn_step_ctrl #(.DEBOUNCE_CYCLES(8), .RUN_PERIOD(10)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .btn_step_i (btn_step),
    .btn_run_i  (btn_run),
    .step_o     (step_o),
    .run_o      (run_o),
    .step_cnt_o (step_cnt_o)
  );

  always @(negedge clk) begin
    if (step_o) pulse_cnt++;
    if (step_o && prev_step) double_cnt++;
    prev_step = step_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 = step_o high, 1 = run_o high, 2 = run_o low; returns edges counted or -1.
  task automatic wait_for(input int which, input int budget, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      case (which)
        0:       found = step_o;
        1:       found = run_o;
        default: found = !run_o;
      endcase
    end
    if (!found) n = -1;
  endtask

  initial begin
    int   n;
    logic run_any;

    #1 rst = 1'b1;
    #1;
    check("reset_step", step_o, 0);
    check("reset_run", run_o, 0);
    check("reset_cnt", step_cnt_o, 0);
    after_edges(2);
    rst = 1'b0;

    // Bouncing step button, then a clean held press.
    for (int i = 0; i < 7; i++) begin
      btn_step = 1'b1; after_edges(3);
      btn_step = 1'b0; after_edges(3);
    end
    btn_step = 1'b1;
    wait_for(0, 40, n);
    check("bounce_latency", n, 11);
    check("bounce_cnt", step_cnt_o, 1);
    after_edges(15);
    check("bounce_pulses", pulse_cnt, 1);
    btn_step = 1'b0;
    after_edges(15);
    btn_step = 1'b1;
    wait_for(0, 40, n);
    check("second_latency", n, 11);
    check("second_cnt", step_cnt_o, 2);
    btn_step = 1'b0;
    after_edges(15);
    check("second_pulses", pulse_cnt, 2);

    // Pre-load the counter near its top so auto-run pulses cross the wrap.
    force dut.step_cnt_q = 16'hFFFE;
    after_edges(1);
    release dut.step_cnt_q;
    after_edges(1);

    btn_run = 1'b1;
    wait_for(1, 40, n);
    check("run_latency", n, 11);
    btn_run = 1'b0;
    wait_for(0, 20, n);
    check("run_period1", n, 10);
    check("cnt_ffff", step_cnt_o, 16'hFFFF);
    btn_step = 1'b1;
    wait_for(0, 20, n);
    check("run_period2", n, 10);
    check("cnt_wrap", step_cnt_o, 16'h0000);
    wait_for(0, 20, n);
    check("run_period3", n, 10);
    check("cnt_after_wrap", step_cnt_o, 16'h0001);
    btn_step = 1'b0;
    btn_run  = 1'b1;
    wait_for(2, 40, n);
    check("run_off_latency", n, 11);
    check("run_off_cnt", step_cnt_o, 2);
    btn_run = 1'b0;
    after_edges(30);
    check("run_off_quiet", pulse_cnt, 6);
    check("run_off_mode", run_o, 0);

    // Simultaneous run + step press in STEP mode.
    btn_run  = 1'b1;
    btn_step = 1'b1;
    wait_for(1, 40, n);
    check("simul_latency", n, 11);
    check("simul_step", step_o, 0);
    check("simul_cnt", step_cnt_o, 2);
    btn_run = 1'b0;
    after_edges(13);
    check("simul_pulses", pulse_cnt, 7);
    check("pre_reset_cnt", step_cnt_o, 3);
    check("pre_reset_run", run_o, 1);

    // Asynchronous reset mid-cycle with the step button still held.
    #3 rst = 1'b1;
    #1;
    check("async_rst_step", step_o, 0);
    check("async_rst_run", run_o, 0);
    check("async_rst_cnt", step_cnt_o, 0);
    after_edges(2);
    rst = 1'b0;
    wait_for(0, 40, n);
    check("post_reset_latency", n, 11);
    check("post_reset_cnt", step_cnt_o, 1);
    check("post_reset_run", run_o, 0);
    btn_step = 1'b0;
    after_edges(15);

    // Short glitches on the run button must be rejected.
    run_any = 1'b0;
    btn_run = 1'b1;
    after_edges(1);
    btn_run = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      run_any |= run_o;
    end
    after_edges(1);
    btn_run = 1'b1;
    after_edges(7);
    btn_run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run_any |= run_o;
    end
    check("glitch_run", run_any, 0);
    after_edges(1);
    check("final_pulses", pulse_cnt, 8);
    check("no_merged_pulses", double_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
